vlsu_sequencer: RTL

Parametrised multi-beat vector load/store sequencer. It replaces the fixed 4-lane, single-cycle vector memory path. It accepts one vector memory request (base, stride, vl, mask) and splits it into beats of NLANES elements. Each beat drives a banked DMEM port set with 1-cycle read latency. It assembles load results into a VLEN-wide writeback register and pulses done. It sits between vector decode/VALU and DMEM.

---
 rtl/vlsu_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/vlsu_sequencer.sv
// Multi-beat vector load/store sequencer: splits one vector memory request into NLANES-wide DMEM beats.
// Define VLSU_INDEXED_EN to add the req_idx port and indexed (mode 10) addressing; otherwise mode 10 is illegal.
module vlsu_sequencer #(
    parameter  int VLEN       = 128,
    parameter  int XLEN       = 32,
    parameter  int NLANES     = 4,
    parameter  int ADDR_WIDTH = 10,
    localparam int MAXEL      = VLEN / XLEN,
    localparam int VLW        = $clog2(MAXEL + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_store,
    input  logic [1:0]                   req_mode,
    input  logic [XLEN-1:0]              req_base,
    input  logic [XLEN-1:0]              req_stride,
    input  logic [VLW-1:0]               req_vl,
    input  logic                         req_vm,
    input  logic [MAXEL-1:0]             req_mask,
    input  logic [VLEN-1:0]              req_vs3,
    input  logic [VLEN-1:0]              req_vd_old,
`ifdef VLSU_INDEXED_EN
    input  logic [VLEN-1:0]              req_idx,
`endif
    output logic [NLANES-1:0]            mem_re,
    output logic [NLANES-1:0]            mem_we,
    output logic [NLANES*ADDR_WIDTH-1:0] mem_addr,
    output logic [NLANES*XLEN-1:0]       mem_wdata,
    input  logic [NLANES*XLEN-1:0]       mem_rdata,
    output logic                         done,
    output logic [VLEN-1:0]              result,
    output logic                         err
);
    localparam int EIW = (MAXEL > 1) ? $clog2(MAXEL) : 1;
`ifdef VLSU_INDEXED_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                      state;
    logic                        storeQ, vmQ;
    logic [1:0]                  modeQ;
    logic [XLEN-1:0]             baseQ, stepQ;
    logic [VLW-1:0]              vlQ, beatQ, lastBeatQ, pendBeatQ;
    logic [MAXEL-1:0]            maskQ;
    logic [VLEN-1:0]             vs3Q;
    logic [NLANES-1:0][XLEN-1:0] laneAddrQ;
    logic [NLANES-1:0]           pendReQ;
`ifdef VLSU_INDEXED_EN
    logic [VLEN-1:0]             idxQ;
`endif

    logic            isIdle, illegalIn;
    logic [XLEN-1:0] stepIn;
    logic [VLW-1:0]  lastBeatIn;

    assign isIdle = (state == IDLE);

    always_comb begin
        stepIn     = (req_mode == 2'b01) ? req_stride : XLEN'(4);
        illegalIn  = (req_mode == 2'b11) || ((req_mode == 2'b10) && !IDX_EN);
        lastBeatIn = VLW'((int'(req_vl) + NLANES - 1) / NLANES - 1);
    end

    // The next beat is computed from the live request while idle, so beat 0 is registered at accept.
    logic                        selStore, selVm;
    logic [1:0]                  selMode;
    logic [XLEN-1:0]             selBase;
    logic [VLW-1:0]              selVl, nBeat;
    logic [MAXEL-1:0]            selMask;
    logic [VLEN-1:0]             selVs3, selIdx;
    logic [NLANES-1:0][XLEN-1:0] nAddr, nWdata;
    logic [NLANES-1:0][EIW-1:0]  eIdx;
    logic [NLANES-1:0]           inRange, live, nRe, nWe;
    logic                        nMis;

    always_comb begin
        selStore = isIdle ? req_store  : storeQ;
        selVm    = isIdle ? req_vm     : vmQ;
        selMode  = isIdle ? req_mode   : modeQ;
        selBase  = isIdle ? req_base   : baseQ;
        selVl    = isIdle ? req_vl     : vlQ;
        selMask  = isIdle ? req_mask   : maskQ;
        selVs3   = isIdle ? req_vs3    : vs3Q;
`ifdef VLSU_INDEXED_EN
        selIdx   = isIdle ? req_idx    : idxQ;
`else
        selIdx   = '0;
`endif
        nBeat    = isIdle ? '0 : beatQ + 1'b1;
        nAddr    = '0;
        nWdata   = '0;
        eIdx     = '0;
        inRange  = '0;
        live     = '0;
        nRe      = '0;
        nWe      = '0;
        nMis     = 1'b0;
        for (int l = 0; l < NLANES; l++) begin
            eIdx[l]    = EIW'(int'(nBeat) * NLANES + l);
            inRange[l] = (int'(nBeat) * NLANES + l) < int'(selVl);
            if (selMode == 2'b10)
                nAddr[l] = selBase + selIdx[int'(eIdx[l])*XLEN +: XLEN];
            else if (isIdle)
                nAddr[l] = req_base + XLEN'(l) * stepIn;
            else
                nAddr[l] = laneAddrQ[l] + XLEN'(NLANES) * stepQ;
            live[l]   = inRange[l] & (selVm | selMask[eIdx[l]]);
            nRe[l]    = live[l] & (nAddr[l][1:0] == 2'b00) & ~selStore;
            nWe[l]    = live[l] & (nAddr[l][1:0] == 2'b00) & selStore;
            nMis      = nMis | (live[l] & (nAddr[l][1:0] != 2'b00));
            nWdata[l] = selVs3[int'(eIdx[l])*XLEN +: XLEN];
        end
    end

    logic [NLANES*ADDR_WIDTH-1:0] nAddrFlat;
    for (genvar g = 0; g < NLANES; g++) begin : gLane
        assign nAddrFlat[g*ADDR_WIDTH +: ADDR_WIDTH] = nAddr[g][ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_re    <= '0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            storeQ    <= 1'b0;
            vmQ       <= 1'b0;
            modeQ     <= '0;
            baseQ     <= '0;
            stepQ     <= '0;
            vlQ       <= '0;
            beatQ     <= '0;
            lastBeatQ <= '0;
            pendBeatQ <= '0;
            maskQ     <= '0;
            vs3Q      <= '0;
            laneAddrQ <= '0;
            pendReQ   <= '0;
`ifdef VLSU_INDEXED_EN
            idxQ      <= '0;
`endif
        end else begin
            done      <= 1'b0;
            // Read data for the beat on the bus arrives one cycle later; track which lanes to capture.
            pendReQ   <= mem_re;
            pendBeatQ <= beatQ;
            for (int l = 0; l < NLANES; l++)
                if (pendReQ[l])
                    result[(int'(pendBeatQ) * NLANES + l) * XLEN +: XLEN] <= mem_rdata[l*XLEN +: XLEN];

            case (state)
                IDLE: if (req_valid) begin
                    storeQ    <= req_store;
                    vmQ       <= req_vm;
                    modeQ     <= req_mode;
                    baseQ     <= req_base;
                    stepQ     <= stepIn;
                    vlQ       <= req_vl;
                    maskQ     <= req_mask;
                    vs3Q      <= req_vs3;
`ifdef VLSU_INDEXED_EN
                    idxQ      <= req_idx;
`endif
                    result    <= req_vd_old;
                    req_ready <= 1'b0;
                    if (req_vl == '0 || illegalIn) begin
                        err   <= illegalIn;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        err       <= nMis;
                        state     <= ISSUE;
                        beatQ     <= '0;
                        lastBeatQ <= lastBeatIn;
                        laneAddrQ <= nAddr;
                        mem_re    <= nRe;
                        mem_we    <= nWe;
                        mem_addr  <= nAddrFlat;
                        mem_wdata <= nWdata;
                    end
                end
                ISSUE: if (beatQ == lastBeatQ) begin
                    mem_re <= '0;
                    mem_we <= '0;
                    if (storeQ) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= DRAIN;
                    end
                end else begin
                    beatQ     <= nBeat;
                    laneAddrQ <= nAddr;
                    mem_re    <= nRe;
                    mem_we    <= nWe;
                    mem_addr  <= nAddrFlat;
                    mem_wdata <= nWdata;
                    if (nMis) err <= 1'b1;
                end
                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
